// File: rtl/defuse_keypad.sv
// ---------------------------------------------------------------------------
// defuse_keypad
//   Operator-input end of the bomb game. The operator sets a BCD digit on the
//   switches and commits it with a push-button. Once CODE_LEN digits have been
//   committed, the code is compared against SECRET. The result is reported to
//   the countdown timer as either a defuse or a strike.
//
// Ports
//   CLOCK_50      in   system clock, every flop on the rising edge
//   RESET_N       in   asynchronous active-low reset (released synchronously)
//   armed         in   high while the timer is counting
//   digit_in[3:0] in   BCD digit from the switches, sampled on an accepted press
//   enter_key     in   raw push-button, active-low, asynchronous to CLOCK_50
//   defused       out  sticky level, set when the correct code is committed
//   strike_pulse  out  one-cycle pulse per wrong complete code
//   strikes[2:0]  out  number of wrong codes so far (saturating)
//   locked_out    out  sticky level, set once strikes reaches MAX_STRIKES
//   digit_err     out  one-cycle pulse when a committed digit is above 9
//   digit_idx[2:0]out  digits entered in the current attempt
//   last_digit[3:0]out most recently accepted digit, for the hex display
// ---------------------------------------------------------------------------
module defuse_keypad #(
  parameter int unsigned CODE_LEN     = 4,
  parameter logic [31:0] SECRET       = 32'h4217,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned MAX_STRIKES  = 3
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       armed,
  input  logic [3:0] digit_in,
  input  logic       enter_key,
  output logic       defused,
  output logic       strike_pulse,
  output logic [2:0] strikes,
  output logic       locked_out,
  output logic       digit_err,
  output logic [2:0] digit_idx,
  output logic [3:0] last_digit
);

  localparam int unsigned CODE_W = 4 * CODE_LEN;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC);

  localparam logic [CODE_W-1:0] SECRET_CODE = SECRET[CODE_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]        IDX_LAST    = 3'(CODE_LEN - 1);
  localparam logic [2:0]        STRIKE_MAX  = 3'(MAX_STRIKES);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    DEFUSED,
    LOCKOUT
  } state_t;

  // -------------------------------------------------------------------------
  // Reset conditioning.
  // Assertion clears everything immediately. Release is retimed so that no
  // flop leaves reset on a partial clock edge.
  // -------------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // -------------------------------------------------------------------------
  // Button path: synchronizer, then debounce counter, then rising-edge press.
  // The counter only runs while the synchronized level disagrees with the
  // debounced level. Any agreement restarts it, so a glitch shorter than
  // DEBOUNCE_CYC cycles never reaches btn_db.
  // -------------------------------------------------------------------------
  logic [1:0]       btn_sync;
  logic             btn_db;
  logic             btn_db_q;
  logic [CNT_W-1:0] db_cnt;
  logic             press;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b00;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_sync <= {btn_sync[0], ~enter_key};
      btn_db_q <= btn_db;
      if (btn_sync[1] != btn_db) begin
        if (db_cnt == CNT_MAX) begin
          btn_db <= ~btn_db;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Only the press edge matters; releases are debounced but otherwise unused.
  assign press = btn_db & ~btn_db_q;

  // -------------------------------------------------------------------------
  // Entry / check state machine
  // -------------------------------------------------------------------------
  state_t            state;
  logic              armed_q;
  logic [CODE_W-1:0] code;
  logic [2:0]        strikes_inc;

  // Saturating increment. Lockout stops further checks in any case, but the
  // counter must never wrap.
  always_comb begin
    strikes_inc = strikes;
    if (strikes != STRIKE_MAX) strikes_inc = strikes + 3'd1;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      armed_q      <= 1'b0;
      code         <= '0;
      defused      <= 1'b0;
      strike_pulse <= 1'b0;
      strikes      <= 3'd0;
      locked_out   <= 1'b0;
      digit_err    <= 1'b0;
      digit_idx    <= 3'd0;
      last_digit   <= 4'd0;
    end else begin
      armed_q      <= armed;
      strike_pulse <= 1'b0;
      digit_err    <= 1'b0;

      case (state)
        // A press landing on the same edge as the arming edge is
        // deliberately dropped. Entry begins on the following cycle.
        IDLE: begin
          if (armed && !armed_q) begin
            state     <= ENTRY;
            digit_idx <= 3'd0;
            code      <= '0;
          end
        end

        ENTRY: begin
          if (!armed) begin
            // Time ran out or the timer was reset. Discard the partial code
            // but keep the strike count.
            state     <= IDLE;
            digit_idx <= 3'd0;
            code      <= '0;
          end else if (press) begin
            if (digit_in > 4'd9) begin
              digit_err <= 1'b1;
            end else begin
              code       <= {code[CODE_W-5:0], digit_in};
              digit_idx  <= digit_idx + 3'd1;
              last_digit <= digit_in;
              // With CODE_LEN = 8 the 3-bit index reads 0 during CHECK.
              // It is cleared or frozen right after, so this is harmless.
              if (digit_idx == IDX_LAST) state <= CHECK;
            end
          end
        end

        // The compare always completes, even if armed dropped on this cycle.
        CHECK: begin
          if (code == SECRET_CODE) begin
            state   <= DEFUSED;
            defused <= 1'b1;
          end else begin
            strikes      <= strikes_inc;
            strike_pulse <= 1'b1;
            digit_idx    <= 3'd0;
            code         <= '0;
            if (strikes_inc == STRIKE_MAX) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
            end else if (armed) begin
              state <= ENTRY;
            end else begin
              state <= IDLE;
            end
          end
        end

        // Terminal states. Only reset leaves them.
        DEFUSED: state <= DEFUSED;
        LOCKOUT: state <= LOCKOUT;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_defuse_keypad.sv
// ---------------------------------------------------------------------------
// tb_defuse_keypad
//   Directed and randomized checks of defuse_keypad with a short debounce.
//   The expected behaviour comes from a digit-queue model of the game rules.
// ---------------------------------------------------------------------------
module tb_defuse_keypad;

  localparam int          CODE_LEN = 4;
  localparam int          DEB      = 4;
  localparam int          MAXS     = 3;
  localparam logic [15:0] SECRET_V = 16'h4217;

  logic       CLOCK_50  = 1'b0;
  logic       RESET_N   = 1'b0;
  logic       armed     = 1'b0;
  logic [3:0] digit_in  = 4'd0;
  logic       enter_key = 1'b1;
  logic       defused;
  logic       strike_pulse;
  logic [2:0] strikes;
  logic       locked_out;
  logic       digit_err;
  logic [2:0] digit_idx;
  logic [3:0] last_digit;

  always #5 CLOCK_50 = ~CLOCK_50;

  defuse_keypad #(
    .CODE_LEN    (CODE_LEN),
    .SECRET      (32'h4217),
    .DEBOUNCE_CYC(DEB),
    .MAX_STRIKES (MAXS)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .armed       (armed),
    .digit_in    (digit_in),
    .enter_key   (enter_key),
    .defused     (defused),
    .strike_pulse(strike_pulse),
    .strikes     (strikes),
    .locked_out  (locked_out),
    .digit_err   (digit_err),
    .digit_idx   (digit_idx),
    .last_digit  (last_digit)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Observed pulse totals
  int err_cnt = 0;
  int sp_cnt  = 0;

  always @(posedge CLOCK_50) begin
    if (digit_err)    err_cnt++;
    if (strike_pulse) sp_cnt++;
  end

  // Reference model: the digits of the current attempt, plus game status
  int q[$];
  int m_str   = 0;
  bit m_def   = 0;
  bit m_lock  = 0;
  bit m_armed = 0;
  int m_last  = 0;
  int exp_err = 0;
  int exp_sp  = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_press(input int d);
    int v;
    if (!m_armed || m_def || m_lock) return;
    if (d > 9) begin
      exp_err++;
      return;
    end
    q.push_back(d);
    m_last = d;
    if (q.size() == CODE_LEN) begin
      v = 0;
      foreach (q[i]) v = v * 16 + q[i];
      if (v == int'(SECRET_V)) begin
        m_def = 1;
      end else begin
        if (m_str < MAXS) m_str++;
        exp_sp++;
        q.delete();
        if (m_str == MAXS) m_lock = 1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".idx"},    digit_idx,  q.size());
    chk({tag, ".strk"},   strikes,    m_str);
    chk({tag, ".def"},    defused,    m_def);
    chk({tag, ".lock"},   locked_out, m_lock);
    chk({tag, ".last"},   last_digit, m_last);
    chk({tag, ".errcnt"}, err_cnt,    exp_err);
    chk({tag, ".spcnt"},  sp_cnt,     exp_sp);
  endtask

  task automatic press(input int d, input string tag);
    digit_in  = 4'(d);
    enter_key = 1'b0;
    tick(10);
    enter_key = 1'b1;
    tick(10);
    model_press(d);
    check_all(tag);
  endtask

  // Hold the raw key low for n cycles, then release it and settle.
  task automatic bounce(input int n, input bit counts, input string tag);
    enter_key = 1'b0;
    tick(n);
    enter_key = 1'b1;
    tick(12);
    if (counts) model_press(int'(digit_in));
    check_all(tag);
  endtask

  task automatic set_armed(input bit b);
    armed = b;
    tick(4);
    if (!b && !m_def && !m_lock) q.delete();
    m_armed = b;
  endtask

  // Reset is checked while RESET_N is still low, so the async clear is what
  // gets observed.
  task automatic do_reset(input string tag);
    RESET_N = 1'b0;
    #1;
    chk({tag, ".rst_idx"},  digit_idx,  0);
    chk({tag, ".rst_strk"}, strikes,    0);
    chk({tag, ".rst_def"},  defused,    0);
    chk({tag, ".rst_lock"}, locked_out, 0);
    chk({tag, ".rst_last"}, last_digit, 0);
    chk({tag, ".rst_sp"},   strike_pulse | digit_err, 0);
    armed     = 1'b0;
    enter_key = 1'b1;
    tick(2);
    RESET_N = 1'b1;
    tick(4);
    q.delete();
    m_str   = 0;
    m_def   = 0;
    m_lock  = 0;
    m_armed = 0;
    m_last  = 0;
  endtask

  initial begin
    int n;
    int r;
    int d;
    int p;

    tick(3);
    do_reset("t0");

    // Correct code. defused must follow the 4th digit by exactly one cycle.
    set_armed(1);
    press(4, "t1.d1");
    press(2, "t1.d2");
    press(1, "t1.d3");
    digit_in  = 4'd7;
    enter_key = 1'b0;
    for (int i = 0; i < 20 && digit_idx != 3'd4; i++) tick(1);
    chk("t1.idx4",     digit_idx, 4);
    chk("t1.def_pre",  defused,   0);
    tick(1);
    chk("t1.def_post", defused,   1);
    enter_key = 1'b1;
    tick(10);
    model_press(7);
    check_all("t1.d4");

    // A wrong code, then the right one.
    do_reset("t2");
    set_armed(1);
    press(4, "t2.a");
    press(2, "t2.b");
    press(1, "t2.c");
    press(8, "t2.d");
    press(4, "t2.e");
    press(2, "t2.f");
    press(1, "t2.g");
    press(7, "t2.h");

    // Three wrong codes lock the game out. A correct code afterwards does nothing.
    do_reset("t3");
    set_armed(1);
    for (int i = 0; i < 12; i++) press(0, "t3.zero");
    press(4, "t3.p4");
    press(2, "t3.p2");
    press(1, "t3.p1");
    press(7, "t3.p7");

    // A non-BCD digit is rejected.
    do_reset("t4");
    set_armed(1);
    press(3,     "t4.ok");
    press(4'hC,  "t4.bad");

    // Bounce filtering
    digit_in = 4'd5;
    bounce(1, 0, "t5.g1");
    bounce(3, 0, "t5.g3");
    bounce(6, 1, "t5.g6");

    // Disarm mid-entry, presses while disarmed, reset mid-entry.
    set_armed(0);
    check_all("t6.disarm");
    press(9, "t6.idle");
    set_armed(1);
    press(1, "t6.w1");
    press(1, "t6.w2");
    press(1, "t6.w3");
    press(1, "t6.w4");
    press(4, "t6.p1");
    press(2, "t6.p2");
    do_reset("t6.mid");

    // Randomized sessions
    for (int round = 0; round < 8; round++) begin
      do_reset("rnd.rst");
      set_armed(1);
      n = $urandom_range(6, 16);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          set_armed(0);
          if ($urandom_range(0, 1) == 1) press($urandom_range(0, 9), "rnd.off");
          set_armed(1);
        end
        r = $urandom_range(0, 9);
        p = q.size();
        if (r == 0)               d = $urandom_range(10, 15);
        else if (r < 6 && p < 4)  d = (int'(SECRET_V) >> (4 * (3 - p))) & 15;
        else                      d = $urandom_range(0, 9);
        press(d, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
